// File: rtl/lab5_divider_toplevel_if.sv
// Board-side bundle of the lab5 divider: load/run controls, switches, register views and hex displays.
interface lab5_divider_toplevel_if;
  logic       ClearA_LoadB;
  logic       Run;
  logic [7:0] SW;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       Busy;
  logic       Done;
  logic       DivZero;
  logic [6:0] AhexL;
  logic [6:0] AhexU;
  logic [6:0] BhexL;
  logic [6:0] BhexU;

  modport master (
    output ClearA_LoadB, Run, SW,
    input  Aval, Bval, Busy, Done, DivZero, AhexL, AhexU, BhexL, BhexU
  );

  modport slave (
    input  ClearA_LoadB, Run, SW,
    output Aval, Bval, Busy, Done, DivZero, AhexL, AhexU, BhexL, BhexU
  );
endinterface

// File: rtl/lab5_divider_toplevel.sv
// Iterative restoring divider: Q holds the dividend and becomes the quotient, A becomes the remainder.
// Define LAB5_DIVIDER_SIGNED_EN for two's-complement operands (adds a FIXUP sign-correction state).
//
// state | meaning
// IDLE  | load dividend (ClearA_LoadB) or latch divisor and start (Run)
// START | divide-by-zero check; signed build takes operand magnitudes
// SHIFT | shift {A,Q} left by one
// SUB   | trial subtract of D from A, set quotient bit
// FIXUP | (signed build) apply quotient/remainder signs
// DONE  | hold result until Run is released
module lab5_divider_toplevel #(
  parameter int WIDTH = 8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  lab5_divider_toplevel_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    SUB,
`ifdef LAB5_DIVIDER_SIGNED_EN
    FIXUP,
`endif
    DONE
  } state_t;

`ifdef LAB5_DIVIDER_SIGNED_EN
  localparam state_t LAST = FIXUP;
`else
  localparam state_t LAST = DONE;
`endif

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg, q_reg, d_reg;
  logic [CW-1:0]    count;
  logic             carry;
  logic             div_zero;
  logic [WIDTH:0]   diff;

`ifdef LAB5_DIVIDER_SIGNED_EN
  logic neg_q, neg_r;
`endif

  // carry holds the bit shifted out of A[MSB]; with it set the subtract can never borrow
  assign diff = {carry, a_reg} - {1'b0, d_reg};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!bus.ClearA_LoadB && bus.Run) state_next = START;
      START:   state_next = (d_reg == '0) ? DONE : SHIFT;
      SHIFT:   state_next = SUB;
      SUB:     state_next = (count == CW'(WIDTH-1)) ? LAST : SHIFT;
`ifdef LAB5_DIVIDER_SIGNED_EN
      FIXUP:   state_next = DONE;
`endif
      DONE:    if (!bus.Run) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      a_reg    <= '0;
      q_reg    <= '0;
      d_reg    <= '0;
      count    <= '0;
      carry    <= 1'b0;
      div_zero <= 1'b0;
`ifdef LAB5_DIVIDER_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.ClearA_LoadB) begin
            a_reg    <= '0;
            q_reg    <= bus.SW;
            div_zero <= 1'b0;
          end else if (bus.Run) begin
            d_reg <= bus.SW;
            count <= '0;
          end
        end
        START: begin
          if (d_reg == '0) begin
            div_zero <= 1'b1;
            q_reg    <= '1;
            a_reg    <= q_reg;
          end else begin
            // a fresh division always starts from an empty partial remainder
            a_reg <= '0;
            carry <= 1'b0;
`ifdef LAB5_DIVIDER_SIGNED_EN
            neg_q <= q_reg[WIDTH-1] ^ d_reg[WIDTH-1];
            neg_r <= q_reg[WIDTH-1];
            q_reg <= q_reg[WIDTH-1] ? -q_reg : q_reg;
            d_reg <= d_reg[WIDTH-1] ? -d_reg : d_reg;
`endif
          end
        end
        SHIFT: {carry, a_reg, q_reg} <= {a_reg, q_reg, 1'b0};
        SUB: begin
          if (!diff[WIDTH]) begin
            a_reg    <= diff[WIDTH-1:0];
            q_reg[0] <= 1'b1;
          end
          count <= count + CW'(1);
        end
`ifdef LAB5_DIVIDER_SIGNED_EN
        FIXUP: begin
          if (neg_q) q_reg <= -q_reg;
          if (neg_r) a_reg <= -a_reg;
        end
`endif
        default: ;
      endcase
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] seg;
    seg = 7'h7F;
    case (n)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  assign bus.Aval    = a_reg;
  assign bus.Bval    = q_reg;
  assign bus.Busy    = (state == START) || (state == SHIFT) || (state == SUB);
  assign bus.Done    = (state == DONE);
  assign bus.DivZero = div_zero;
  assign bus.AhexL   = hex7(a_reg[3:0]);
  assign bus.AhexU   = hex7(a_reg[7:4]);
  assign bus.BhexL   = hex7(q_reg[3:0]);
  assign bus.BhexU   = hex7(q_reg[7:4]);

endmodule

// File: tb/tb_lab5_divider_toplevel.sv
// Bench for lab5_divider_toplevel: arithmetic reference model checked every cycle plus directed literal checks.
module tb_lab5_divider_toplevel;

`ifdef LAB5_DIVIDER_SIGNED_EN
  localparam bit SIGNED_MODE = 1'b1;
  localparam int LAT = 19;
`else
  localparam bit SIGNED_MODE = 1'b0;
  localparam int LAT = 18;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  lab5_divider_toplevel_if bus();

  lab5_divider_toplevel #(.WIDTH(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  logic [6:0] seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: phase of the operation plus the values the registers must show
  typedef enum int {P_IDLE, P_BUSY, P_DONE} phase_t;
  phase_t     ph = P_IDLE;
  logic [7:0] m_a = 8'h00, m_q = 8'h00, r_a = 8'h00, r_q = 8'h00;
  logic       m_dz = 1'b0, r_dz = 1'b0;
  int         left = 0;
  int         sd, sv, rq, rr;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ph = P_IDLE; m_a = 8'h00; m_q = 8'h00; m_dz = 1'b0;
    end else begin
      case (ph)
        P_IDLE: begin
          if (bus.ClearA_LoadB) begin
            m_a = 8'h00; m_q = bus.SW; m_dz = 1'b0;
          end else if (bus.Run) begin
            if (bus.SW == 8'h00) begin
              r_q = 8'hFF; r_a = m_q; r_dz = 1'b1; left = 1;
            end else begin
              if (SIGNED_MODE) begin
                sd = int'($signed(m_q)); sv = int'($signed(bus.SW));
              end else begin
                sd = int'(m_q); sv = int'(bus.SW);
              end
              rq = sd / sv; rr = sd % sv;
              r_q = rq[7:0]; r_a = rr[7:0]; r_dz = m_dz; left = LAT - 1;
            end
            ph = P_BUSY;
          end
        end
        P_BUSY: begin
          left--;
          if (left == 0) begin
            ph = P_DONE; m_a = r_a; m_q = r_q; m_dz = r_dz;
          end
        end
        P_DONE: if (!bus.Run) ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
    end
  end

  always @(negedge Clk) begin
    if (ph == P_BUSY) begin
      chk("busy_done", int'(bus.Done), 0);
      chk("busy_busy", int'(bus.Busy), int'(!(SIGNED_MODE && !r_dz && left == 1)));
    end else begin
      chk("done", int'(bus.Done), int'(ph == P_DONE));
      chk("busy", int'(bus.Busy), 0);
      chk("aval", int'(bus.Aval), int'(m_a));
      chk("bval", int'(bus.Bval), int'(m_q));
      chk("divzero", int'(bus.DivZero), int'(m_dz));
      chk("ahexl", int'(bus.AhexL), int'(seg[m_a[3:0]]));
      chk("ahexu", int'(bus.AhexU), int'(seg[m_a[7:4]]));
      chk("bhexl", int'(bus.BhexL), int'(seg[m_q[3:0]]));
      chk("bhexu", int'(bus.BhexU), int'(seg[m_q[7:4]]));
    end
  end

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic load(input logic [7:0] v);
    bus.ClearA_LoadB = 1'b1;
    bus.SW = v;
    step();
    bus.ClearA_LoadB = 1'b0;
  endtask

  task automatic run_div(input logic [7:0] dv, input int lat);
    int n;
    n = 0;
    bus.SW = dv;
    bus.Run = 1'b1;
    do begin
      @(posedge Clk);
      #1;
      n++;
    end while (!bus.Done && n < 60);
    chk("latency", n, lat);
    #1;
  endtask

  task automatic release_run();
    bus.Run = 1'b0;
    step();
  endtask

  task automatic lit(input string name, input logic [7:0] q, input logic [7:0] a, input logic dz);
    chk({name, "_q"}, int'(bus.Bval), int'(q));
    chk({name, "_a"}, int'(bus.Aval), int'(a));
    chk({name, "_dz"}, int'(bus.DivZero), int'(dz));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ClearA_LoadB = 1'b0;
    bus.Run = 1'b0;
    bus.SW = 8'h00;
    #12;
    chk("rst_bval", int'(bus.Bval), 0);
    chk("rst_hex", int'(bus.AhexL), 7'h40);
    Reset = 1'b1;
    step();

    load(8'd100);
    run_div(8'd7, LAT);
    lit("d100_7", 8'h0E, 8'h02, 1'b0);
    release_run();
    chk("d100_7_idle", int'(bus.Done), 0);

    load(8'hFF);
    run_div(8'h01, LAT);
    lit("dff_1", 8'hFF, 8'h00, 1'b0);
    release_run();

    load(8'h05);
    run_div(8'h09, LAT);
    lit("d5_9", 8'h00, 8'h05, 1'b0);
    release_run();

    load(8'h2A);
    run_div(8'h00, 2);
    lit("dzero", 8'hFF, 8'h2A, 1'b1);
    release_run();
    load(8'h10);
    lit("dz_clear", 8'h10, 8'h00, 1'b0);

    load(8'd200);
    bus.SW = 8'd3;
    bus.Run = 1'b1;
    repeat (6) step();
    Reset = 1'b0;
    #1;
    chk("arst_a", int'(bus.Aval), 0);
    chk("arst_q", int'(bus.Bval), 0);
    chk("arst_busy", int'(bus.Busy), 0);
    chk("arst_done", int'(bus.Done), 0);
    chk("arst_bhex", int'(bus.BhexU), 7'h40);
    bus.Run = 1'b0;
    step();
    Reset = 1'b1;
    step();
    load(8'd200);
    run_div(8'd3, LAT);
    if (SIGNED_MODE) lit("d200_3", 8'hEE, 8'hFE, 1'b0);
    else             lit("d200_3", 8'h42, 8'h02, 1'b0);
    release_run();

    load(8'd50);
    bus.SW = 8'd6;
    bus.Run = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 5) begin
        bus.ClearA_LoadB = 1'b1;
        bus.SW = 8'h11;
      end
      if (c == 6) bus.ClearA_LoadB = 1'b0;
    end
    chk("hold_done", int'(bus.Done), 1);
    lit("hold", 8'h08, 8'h02, 1'b0);
    release_run();
    chk("hold_idle", int'(bus.Done), 0);
    chk("hold_keep", int'(bus.Bval), 8'h08);

`ifdef LAB5_DIVIDER_SIGNED_EN
    load(8'h9C);
    run_div(8'h07, 19);
    lit("s9c_7", 8'hF2, 8'hFE, 1'b0);
    release_run();
    load(8'h80);
    run_div(8'hFF, 19);
    lit("s80_ff", 8'h80, 8'h00, 1'b0);
    release_run();
`endif

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
